// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder.
// MMIO register offsets, DBG_STAT bit positions and region decode.
package dmem_pkg;

  localparam logic [15:0] OFF_CYCLE    = 16'h0000;
  localparam logic [15:0] OFF_DBG_TX   = 16'h0004;
  localparam logic [15:0] OFF_DBG_STAT = 16'h0008;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_UNMAP = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

endpackage

// File: rtl/dmem_responder_dbg_fifo.sv
// Debug-output FIFO with extra-bit pointers for full/empty.
// A push while full is accepted only if a pop frees a slot that edge.
module dbg_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic [31:0] head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        drop_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & full_o & ~pop_ok;

  assign head_o = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// Core data-port responder: word RAM plus CYCLE/DBG_TX/DBG_STAT MMIO.
// Cycle counter present only when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic [31:0] dbg_data,
  output logic        dbg_valid,
  input  logic        dbg_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  region_e     region;
  logic [15:0] off;
  logic [AW-1:0] widx;
  logic        wr;
  logic        is_cyc;
  logic        is_tx;
  logic        is_stat;
  logic        bad;
  logic        stat_wr;

  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] cyc_rd;
  logic [31:0] stat;
  logic        ovf_q, ovf_d;
  logic        unm_q, unm_d;

  logic        f_full;
  logic        f_empty;
  logic        f_drop;

  always_comb begin
    region = REG_UNMAPPED;
    if ({1'b0, daddr} < RAM_BYTES)
      region = REG_RAM;
    else if (daddr[31:16] == MMIO_BASE[31:16])
      region = REG_MMIO;
  end

  assign off  = daddr[15:0];
  assign widx = daddr[AW+1:2];
  assign wr   = |we;

  assign is_cyc  = (region == REG_MMIO) && (off == OFF_CYCLE);
  assign is_tx   = (region == REG_MMIO) && (off == OFF_DBG_TX);
  assign is_stat = (region == REG_MMIO) && (off == OFF_DBG_STAT);
  assign bad     = (region == REG_UNMAPPED) ||
                   ((region == REG_MMIO) &&
                    !(is_cyc || is_tx || is_stat));
  assign stat_wr = is_stat && we[0];

  always_ff @(posedge clk) begin
    if (reset_n && region == REG_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) ram_q[widx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  // Clear-write takes priority over the free-running increment
  assign cyc_d = (wr && is_cyc) ? '0 : cyc_q + 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  dbg_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (wr && is_tx),
    .pop_i   (dbg_ready),
    .data_i  (dwdata),
    .head_o  (dbg_data),
    .full_o  (f_full),
    .empty_o (f_empty),
    .drop_o  (f_drop)
  );

  assign dbg_valid = ~f_empty;

  always_comb begin
    stat             = '0;
    stat[STAT_EMPTY] = f_empty;
    stat[STAT_FULL]  = f_full;
    stat[STAT_UNMAP] = unm_q;
    stat[STAT_OVF]   = ovf_q;
  end

  always_comb begin
    unm_d = unm_q;
    ovf_d = ovf_q;
    if (stat_wr && dwdata[STAT_UNMAP]) unm_d = 1'b0;
    if (wr && bad)                     unm_d = 1'b1;
    if (stat_wr && dwdata[STAT_OVF])   ovf_d = 1'b0;
    if (f_drop)                        ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unm_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unm_q <= unm_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    drdata = '0;
    unique case (1'b1)
      (region == REG_RAM): drdata = ram_q[widx];
      is_cyc:              drdata = cyc_rd;
      is_stat:             drdata = stat;
      default:             drdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic
// compared against a queue/array reference model.
module tb_dmem_responder;

  localparam int DW = 64;
  localparam int FD = 4;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX   = 32'hFFFF_0004;
  localparam logic [31:0] A_STAT = 32'hFFFF_0008;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam logic [31:0] CYC10 = 32'd10;
`else
  localparam logic [31:0] CYC10 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic        dbg_ready;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DW),
    .FIFO_DEPTH  (FD),
    .MMIO_BASE   (32'hFFFF_0000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .we        (we),
    .drdata    (drdata),
    .dbg_data  (dbg_data),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_ram [DW];
  logic [3:0]  m_kn  [DW];
  logic [31:0] m_q [$];
  logic [31:0] m_cyc;
  bit          m_ovf;
  bit          m_unm;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s    = '0;
    s[0] = (m_q.size() == 0);
    s[1] = (m_q.size() == FD);
    s[2] = m_unm;
    s[3] = m_ovf;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a,
                                         output bit kn);
    int k;
    kn = 1'b1;
    if (a < 32'(4 * DW)) begin
      k  = int'(a >> 2);
      kn = (m_kn[k] == 4'hF);
      return m_ram[k];
    end
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
`ifdef DMEM_CYCLE_COUNTER_EN
        16'h0000: return m_cyc;
`endif
        16'h0008: return m_stat();
        default:  return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] w, input bit rdy);
    bit push;
    bit clr;
    bit pop;
    int sz;
    int k;
    push = 1'b0;
    clr  = 1'b0;
    sz   = m_q.size();
    pop  = rdy && (sz > 0);
    if (a < 32'(4 * DW)) begin
      k = int'(a >> 2);
      for (int i = 0; i < 4; i++) begin
        if (w[i]) begin
          m_ram[k][8*i +: 8] = wd[8*i +: 8];
          m_kn[k][i] = 1'b1;
        end
      end
    end else if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0000: clr  = (w != 0);
        16'h0004: push = (w != 0);
        16'h0008: begin
          if (w[0] && wd[3]) m_ovf = 1'b0;
          if (w[0] && wd[2]) m_unm = 1'b0;
        end
        default: if (w != 0) m_unm = 1'b1;
      endcase
    end else if (w != 0) begin
      m_unm = 1'b1;
    end
    m_cyc = clr ? 32'h0 : m_cyc + 32'd1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < FD || pop) m_q.push_back(wd);
      else                m_ovf = 1'b1;
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_cyc = 32'h0;
    m_ovf = 1'b0;
    m_unm = 1'b0;
  endtask

  // One bus cycle: drive, check outputs mid-cycle, advance the model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] w, input bit rdy);
    bit          kn;
    logic [31:0] e;
    daddr     = a;
    dwdata    = wd;
    we        = w;
    dbg_ready = rdy;
    @(negedge clk);
    e = m_read(a, kn);
    if (kn) chk("drdata", drdata, e);
    chk("dbg_valid", 32'(dbg_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("dbg_data", dbg_data, m_q[0]);
    @(posedge clk);
    m_edge(a, wd, w, rdy);
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
    daddr = a;
    we    = 4'h0;
    #1;
    chk(tag, drdata, exp);
  endtask

  initial begin
    for (int i = 0; i < DW; i++) m_kn[i] = 4'h0;
    m_reset();
    reset_n   = 1'b0;
    daddr     = A_CYC;
    dwdata    = '0;
    we        = 4'h0;
    dbg_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(dbg_valid), 32'h0);
    chk("rst_data", dbg_data, 32'h0);
    chk("rst_cycle", drdata, 32'h0);
    peek("rst_stat", A_STAT, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) cyc(32'h0, 32'h0, 4'h0, 1'b0);
    peek("cycle10", A_CYC, CYC10);
    cyc(A_CYC, 32'h0, 4'hF, 1'b0);
    peek("cycle_clr", A_CYC, 32'h0);

    cyc(32'h10, 32'hAABBCCDD, 4'hF, 1'b0);
    cyc(32'h10, 32'h00000011, 4'h1, 1'b0);
    peek("lane0", 32'h10, 32'hAABBCC11);
    cyc(32'h10, 32'h22000000, 4'h8, 1'b0);
    peek("lane3", 32'h10, 32'h22BBCC11);

    for (int i = 1; i <= 5; i++) cyc(A_TX, 32'(i), 4'hF, 1'b0);
    peek("stat_ovf", A_STAT, 32'hA);
    cyc(A_STAT, 32'h8, 4'h1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(32'h0, 32'h0, 4'h0, 1'b1);
    chk("drained", 32'(dbg_valid), 32'h0);

    for (int i = 5; i <= 8; i++) cyc(A_TX, 32'(i), 4'hF, 1'b0);
    cyc(A_TX, 32'h9, 4'hF, 1'b1);
    peek("full_pp", A_STAT, 32'h2);
    for (int i = 0; i < 4; i++) cyc(32'h0, 32'h0, 4'h0, 1'b1);

    cyc(32'h4000_0000, 32'h5, 4'hF, 1'b0);
    peek("unm_set", A_STAT, 32'h5);
    peek("unm_rd", 32'h4000_0000, 32'h0);
    cyc(A_STAT, 32'h4, 4'h1, 1'b0);
    peek("unm_clr", A_STAT, 32'h1);

    cyc(32'h20, 32'h12345678, 4'hF, 1'b0);
    cyc(A_TX, 32'hA1, 4'hF, 1'b0);
    cyc(A_TX, 32'hA2, 4'hF, 1'b0);
    daddr  = 32'h20;
    dwdata = 32'hDEADBEEF;
    we     = 4'hF;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dbg_valid), 32'h0);
    @(posedge clk);
    #1;
    peek("arst_stat", A_STAT, 32'h1);
    peek("arst_wr", 32'h20, 32'h12345678);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();

    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  w;
      bit          r;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a = 32'($urandom_range(0, 4 * DW - 1));
        4:          a = A_CYC;
        5, 6:       a = A_TX;
        7:          a = A_STAT;
        8:          a = 32'h0000_1000 | 32'($urandom_range(0, 255));
        default:    a = 32'hFFFF_000C;
      endcase
      w  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      wd = $urandom;
      r  = 1'($urandom_range(0, 1));
      cyc(a, wd, w, r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: services the core's daddr/drdata/dwdata/we port from an internal word RAM and a small MMIO window. MMIO provides a free-running cycle counter and a debug-output FIFO drained by an external consumer over a valid/ready handshake. Sits between the core's data port and the top level, beside the instruction memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-b words (power of two); RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- FIFO_DEPTH, 4, debug FIFO entries (power of two, ≥2).
- MMIO_BASE, 32'hFFFF_0000, base byte address of MMIO window (64 KiB aligned).

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock, shared with the core.
- reset_n  input  1  asynchronous active-low reset.
- daddr  input  32  byte address from core.
- dwdata  input  32  write data, already lane-aligned by core.
- we  input  4  byte-lane write enables; 4'b0000 = read.
- drdata  output  32  read data, combinational from daddr.
- dbg_data  output  32  head word of debug FIFO.
- dbg_valid  output  1  FIFO non-empty.
- dbg_ready  input  1  consumer accepts head word.

## Operation
- Decode: RAM if daddr < 4*DEPTH_WORDS; MMIO if daddr[31:16] == MMIO_BASE[31:16]; else unmapped.
- RAM: word index daddr[log2(DEPTH_WORDS)+1:2]; daddr[1:0] ignored. Read is asynchronous. Write at posedge, each lane i with we[i]=1 updates byte i only. RAM contents are not reset.
- MMIO offsets (daddr[15:0]; other offsets unmapped):
  - 0x0000 CYCLE: read returns counter; write with any we lane clears it.
  - 0x0004 DBG_TX: write with any we lane pushes full dwdata into FIFO; read returns 0.
  - 0x0008 DBG_STAT: read {28'b0, overflow, unmapped_err, full, empty}; write with we[0]=1 clears overflow where dwdata[3]=1 and unmapped_err where dwdata[2]=1.
- Unmapped: read returns 32'h0; write ignored and sets sticky unmapped_err.
- FIFO push when full: word dropped, overflow set. Push and pop in the same cycle while full: pop frees the slot and push is accepted, no overflow. Push and pop while empty: push only; the word appears next cycle.
- dbg_data is valid only while dbg_valid=1. Pop occurs on posedge with dbg_valid & dbg_ready.

## Timing
- Reset values: cycle counter 0, FIFO empty, dbg_valid 0, dbg_data 0, overflow 0, unmapped_err 0. drdata stays combinational during reset and reflects the reset MMIO state.
- drdata: zero-cycle latency from daddr, matching the core's MEM-stage sampling.
- RAM and MMIO writes take effect at the posedge where we is sampled. A read of the same address in the next cycle returns the new value.
- Cycle counter: +1 every posedge, wraps 32'hFFFF_FFFF → 0. A clear-write wins over the increment, so the counter reads 0 in the cycle after the write.
- FIFO: dbg_valid rises 1 cycle after the first push into an empty FIFO. Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
- DBG_STAT reads reflect pre-edge state, with no same-cycle bypass of a push.
- reset_n asserted mid-transfer: FIFO contents discarded immediately, and an in-flight write in that cycle is lost.

## Configuration
- DMEM_CYCLE_COUNTER_EN defined: CYCLE register implemented as above.
- Not defined: no counter flops. CYCLE offset reads 32'h0, writes are ignored, and it is still a mapped offset (does not set unmapped_err).

## Structure
- Package dmem_pkg: MMIO offset constants (CYCLE, DBG_TX, DBG_STAT), DBG_STAT bit positions, region-decode enum {REG_RAM, REG_MMIO, REG_UNMAPPED}.
- One sub-module: dbg_fifo (parameterized FIFO_DEPTH, push/pop/full/empty/head). Decode, RAM and MMIO registers stay in dmem_responder.

## Test plan
- Byte lanes: write 32'hAABBCCDD we=4'hF to 0x10, then 32'h00000011 we=4'h1 → read 0x10 = 32'hAABBCC11; then 32'h22000000 we=4'h8 → read 0x10 = 32'h22BBCC11.
- Counter: release reset, read CYCLE 10 cycles later = 10; write CYCLE → next-cycle read 0. Without DMEM_CYCLE_COUNTER_EN, reads are always 0.
- FIFO fill/overflow: dbg_ready=0, push 1,2,3,4,5 → DBG_STAT = 0b1010 (overflow, full); then dbg_ready=1 drains 1,2,3,4 in order, dbg_valid falls after 4.
- Full push+pop: FIFO full, dbg_ready=1 with push 9 in the same cycle → no overflow, 9 emerges after the three remaining words.
- Unmapped: write 0x4000_0000 → DBG_STAT bit2=1, read 0x4000_0000 = 0; write DBG_STAT 32'h4 → bit2=0.
- Async reset: assert reset_n mid-stream with 2 words queued → dbg_valid=0 immediately, DBG_STAT = 0b0001.
